// File: rtl/qsfa_pkg.sv
// Shared definitions for the quantizer scale-factor adaptation block:
// scale-factor limits, the sequencing FSM states and the per-channel
// scale-factor record stored in the register file.
package qsfa_pkg;

    localparam int YU_MIN  = 544;
    localparam int YU_MAX  = 5120;
    localparam int YL_RST  = YU_MIN << 6;   // slow factor carries 6 extra fraction bits

    // Storage widths of one channel record (fast factor, slow factor)
    localparam int YU_BITS = 13;
    localparam int YL_BITS = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_UPD  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [YU_BITS-1:0] yu;
        logic [YL_BITS-1:0] yl;
    } ch_state_t;

endpackage

// File: rtl/qsfa_arith.sv
// Combinational scale-factor datapath.
//   MIX  : Y   = YLP + sign(DIF) * ((|DIF| * AL) >> 6), YLP = YL >> 6
//   FILTD: YUT = Y + floor((WI - Y) / 32)
//   LIMB : YU' = clamp(YUT, YU_MIN, YU_MAX)
//   FILTE: YL' = YL + floor(((YU' << 6) - YL) / 64)
// Everything is computed in a common signed width wide enough that no
// intermediate value can wrap.
module qsfa_arith #(
    parameter int WI_W   = 12,
    parameter int Y_W    = 13,
    parameter int YL_W   = 19,
    parameter int AL_W   = 7,
    parameter int YU_MIN = 544,
    parameter int YU_MAX = 5120
) (
    input  logic [Y_W-1:0]         yu,
    input  logic [YL_W-1:0]        yl,
    input  logic [AL_W-1:0]        al,
    input  logic signed [WI_W-1:0] wi,
    input  logic [Y_W-1:0]         y,
    output logic [Y_W-1:0]         y_mix,
    output logic [Y_W-1:0]         yu_new,
    output logic [YL_W-1:0]        yl_new
);

    localparam int AW = YL_W + 8;
    localparam logic signed [AW-1:0] LIM_LO = AW'(YU_MIN);
    localparam logic signed [AW-1:0] LIM_HI = AW'(YU_MAX);

    logic signed [AW-1:0] ylp;
    logic signed [AW-1:0] dif;
    logic signed [AW-1:0] mag;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] y_full;
    logic signed [AW-1:0] y_x;
    logic signed [AW-1:0] yut;
    logic signed [AW-1:0] yu_c;
    logic signed [AW-1:0] yl_x;
    logic signed [AW-1:0] yl_full;

    // MIX: blend fast and slow factors by AL; product truncates toward zero
    always_comb begin
        ylp    = AW'(yl >> 6);
        dif    = AW'(yu) - ylp;
        mag    = dif[AW-1] ? -dif : dif;
        prod   = (mag * AW'(al)) >>> 6;
        if (dif[AW-1]) begin
            prod = -prod;
        end
        y_full = ylp + prod;
    end

    assign y_mix = Y_W'(y_full);

    // FILTD / LIMB / FILTE: adapt the fast factor toward WI, then low-pass into YL
    always_comb begin
        y_x  = AW'(y);
        yut  = y_x + ((AW'(wi) - y_x) >>> 5);
        // NOTE: yu_c gets a value on every path through the if/else chain; a
        // missing branch here would silently infer a latch.
        if (yut < LIM_LO) begin
            yu_c = LIM_LO;
        end else if (yut > LIM_HI) begin
            yu_c = LIM_HI;
        end else begin
            yu_c = yut;
        end
        yl_x    = AW'(yl);
        yl_full = yl_x + (((yu_c <<< 6) - yl_x) >>> 6);
    end

    assign yu_new = Y_W'(yu_c);
    assign yl_new = YL_W'(yl_full);

endmodule

// File: rtl/quan_scal_fac_adap_mc.sv
// Multi-channel quantizer scale-factor adaptation (G.726 MIX/FILTD/LIMB/FILTE).
// One request at a time walks IDLE -> MIX -> UPD -> OUT; the per-channel
// fast/slow scale factors live in a flop register file.
// Optional feature macro: QSFA_CH_CLEAR_EN adds ch_clr / ch_clr_id, which
// return one channel to its initial scale factors (a clear beats a
// simultaneous update of the same channel).
module quan_scal_fac_adap_mc #(
    parameter int NCH    = 4,
    parameter int WI_W   = 12,
    parameter int Y_W    = 13,
    parameter int YL_W   = 19,
    parameter int AL_W   = 7,
    parameter int YU_MIN = qsfa_pkg::YU_MIN,
    parameter int YU_MAX = qsfa_pkg::YU_MAX,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scan_in0,
    input  logic                   scan_en,
    output logic                   scan_out0,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH_W-1:0]        in_ch,
    input  logic signed [WI_W-1:0] in_wi,
    input  logic [AL_W-1:0]        in_al,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [Y_W-1:0]         out_y,
    output logic                   out_err
`ifdef QSFA_CH_CLEAR_EN
    ,
    input  logic                   ch_clr,
    input  logic [CH_W-1:0]        ch_clr_id
`endif
);

    import qsfa_pkg::*;

    localparam logic [AL_W-1:0] AL_SAT    = AL_W'(64);
    localparam ch_state_t       RST_STATE = '{yu: YU_BITS'(YU_MIN), yl: YL_BITS'(YU_MIN << 6)};

    state_t                 state_q;
    state_t                 state_d;
    logic [CH_W-1:0]        ch_q;
    logic signed [WI_W-1:0] wi_q;
    logic [AL_W-1:0]        al_q;
    logic                   err_q;
    logic [Y_W-1:0]         y_q;
    ch_state_t              regs_q [NCH];
    ch_state_t              cur;
    logic [Y_W-1:0]         y_mix;
    logic [Y_W-1:0]         yu_new;
    logic [YL_W-1:0]        yl_new;
    logic                   unused_scan;

    function automatic logic ch_oor(input logic [CH_W-1:0] ch);
        return {1'b0, ch} >= (CH_W+1)'(NCH);
    endfunction

    // Scan pins are stitched by DFT; functionally the chain output is tied low
    assign scan_out0   = 1'b0;
    assign unused_scan = scan_in0 ^ scan_en;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign out_ch    = ch_q;
    assign out_y     = y_q;
    assign out_err   = err_q;

    // FSM state register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed walk, waiting only for the two handshakes
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_MIX;
            ST_MIX:  state_d = ST_UPD;
            ST_UPD:  state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture and Y register; outputs are driven straight from here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_q  <= '0;
            wi_q  <= '0;
            al_q  <= '0;
            err_q <= 1'b0;
            y_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                ch_q  <= in_ch;
                wi_q  <= in_wi;
                al_q  <= (in_al > AL_SAT) ? AL_SAT : in_al;
                err_q <= ch_oor(in_ch);
            end
            if (state_q == ST_MIX) begin
                y_q <= err_q ? '0 : y_mix;
            end
        end
    end

    // Channel read port; an out-of-range channel never touches the file
    always_comb begin
        cur = RST_STATE;
        if (!err_q) begin
            cur = regs_q[ch_q];
        end
    end

    qsfa_arith #(
        .WI_W   (WI_W),
        .Y_W    (Y_W),
        .YL_W   (YL_W),
        .AL_W   (AL_W),
        .YU_MIN (YU_MIN),
        .YU_MAX (YU_MAX)
    ) u_arith (
        .yu     (cur.yu),
        .yl     (cur.yl),
        .al     (al_q),
        .wi     (wi_q),
        .y      (y_q),
        .y_mix  (y_mix),
        .yu_new (yu_new),
        .yl_new (yl_new)
    );

    // Channel register file: adapted factors written in UPD, optional clear last so it wins
    // NOTE: the file is plain flops with async reset because every channel must
    // wake up at its initial scale factor; a RAM could not be cleared this way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                regs_q[i] <= RST_STATE;
            end
        end else begin
            if (state_q == ST_UPD && !err_q) begin
                regs_q[ch_q] <= '{yu: yu_new, yl: yl_new};
            end
`ifdef QSFA_CH_CLEAR_EN
            if (ch_clr && !ch_oor(ch_clr_id)) begin
                regs_q[ch_clr_id] <= RST_STATE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_quan_scal_fac_adap_mc.sv
// Self-checking bench for quan_scal_fac_adap_mc (default build, NCH=4).
// Expected scale factors come from a per-channel arithmetic model of the
// G.726 adaptation equations using plain integer floor division.
module tb_quan_scal_fac_adap_mc;

    localparam int NCH  = 4;
    localparam int CH_W = 2;
    localparam int WI_W = 12;
    localparam int Y_W  = 13;
    localparam int AL_W = 7;

    logic                   clk;
    logic                   reset;
    logic                   scan_in0;
    logic                   scan_en;
    logic                   scan_out0;
    logic                   in_valid;
    logic                   in_ready;
    logic [CH_W-1:0]        in_ch;
    logic signed [WI_W-1:0] in_wi;
    logic [AL_W-1:0]        in_al;
    logic                   out_valid;
    logic                   out_ready;
    logic [CH_W-1:0]        out_ch;
    logic [Y_W-1:0]         out_y;
    logic                   out_err;

    int n_tests = 0;
    int n_fail  = 0;

    int m_yu [NCH];
    int m_yl [NCH];

    quan_scal_fac_adap_mc dut (
        .clk       (clk),
        .reset     (reset),
        .scan_in0  (scan_in0),
        .scan_en   (scan_en),
        .scan_out0 (scan_out0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_wi     (in_wi),
        .in_al     (in_al),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_y     (out_y),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_yu[i] = 544;
            m_yl[i] = 544 * 64;
        end
    endfunction

    function automatic int model_y(input int ch, input int al);
        int a, ylp, dif, mag, p;
        a   = (al > 64) ? 64 : al;
        ylp = m_yl[ch] / 64;
        dif = m_yu[ch] - ylp;
        mag = (dif < 0) ? -dif : dif;
        p   = (mag * a) / 64;
        if (dif < 0) p = -p;
        return ylp + p;
    endfunction

    function automatic void model_update(input int ch, input int wi, input int y);
        int yut, yu;
        yut = y + fdiv(wi - y, 32);
        yu  = (yut < 544) ? 544 : ((yut > 5120) ? 5120 : yut);
        m_yl[ch] = m_yl[ch] + fdiv(yu * 64 - m_yl[ch], 64);
        m_yu[ch] = yu;
    endfunction

    // One full transaction; entered and left #1 after a rising edge
    task automatic send(input int ch, input int wi, input int al, input int stall);
        int exp_y;
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_ch    = ch[CH_W-1:0];
        in_wi    = wi[WI_W-1:0];
        in_al    = al[AL_W-1:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_y = model_y(ch, al);
        model_update(ch, wi, exp_y);
        check("busy_ready", in_ready, 0);
        @(posedge clk); #1;
        check("early_valid", out_valid, 0);
        @(posedge clk); #1;
        check("out_valid", out_valid, 1);
        check("out_y", out_y, exp_y);
        check("out_ch", out_ch, ch);
        check("out_err", out_err, 0);
        check("y_range", (out_y >= 544 && out_y <= 5120), 1);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_y", out_y, exp_y);
            check("hold_ch", out_ch, ch);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ready_after", in_ready, 1);
        check("valid_after", out_valid, 0);
    endtask

    function automatic int rand_wi();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial begin
        clk       = 1'b0;
        reset     = 1'b0;
        scan_in0  = 1'b0;
        scan_en   = 1'b0;
        in_valid  = 1'b0;
        in_ch     = '0;
        in_wi     = '0;
        in_al     = '0;
        out_ready = 1'b0;
        model_reset();

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_err", out_err, 0);
        check("rst_scan_out", scan_out0, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Lower clamp: YU would drop to 527 but is held at 544
        send(0, 0, 0, 0);
        send(0, 0, 0, 0);
        // Fast factor grows toward a large WI
        send(1, 2047, 64, 0);
        send(1, 2047, 64, 0);

        // Push ch2 up, then read the slow factor alone, the midpoint, and a saturated AL
        for (int i = 0; i < 30; i++) send(2, 2047, 64, 0);
        send(2, 2047, 0, 0);
        send(2, 2047, 32, 0);
        send(2, -2048, 127, 0);
        send(2, -2048, 100, 0);

        // Interleaved channels keep independent histories
        for (int i = 0; i < 12; i++) send((i % 2 == 0) ? 0 : 3, rand_wi(), int'($urandom_range(0, 127)), 0);

        // Back-pressure: result held for 5 cycles
        send(1, rand_wi(), 40, 5);

        // Random mix of channels, values and stalls
        for (int i = 0; i < 40; i++)
            send(int'($urandom_range(0, NCH - 1)), rand_wi(), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 2)));

        // Reset while the sample sits in UPD: dropped, and the channel restarts
        in_valid = 1'b1;
        in_ch    = 2'd2;
        in_wi    = 12'sd1000;
        in_al    = 7'd64;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_y", out_y, 0);
        check("mid_rst_out_ch", out_ch, 0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        send(2, 2047, 64, 0);
        send(2, 2047, 64, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
